// File: rtl/smult_pkg.sv
// Shared types and constants for the scalar x vector half-precision multiply sequencer.
package smult_pkg;
  localparam int VLEN  = 16;
  localparam int IDX_W = 4;
  localparam int REG_W = 3;

  localparam logic [15:0] ONE     = 16'h3c00;
  localparam logic [15:0] NEG_ONE = 16'hbc00;
  localparam logic [15:0] MAX     = 16'h7bff;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_t;
endpackage

// File: rtl/smult_tag_pipe.sv
// Delay line of {valid, idx} tags that tracks each issued read until its product returns.
module smult_tag_pipe #(
  parameter int IDX_W = 4,
  parameter int DEPTH = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx,
  output logic             any_vld
);
  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0][IDX_W-1:0] idx_pipe;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[DEPTH-2:0], in_vld};
      idx_pipe <= {idx_pipe[DEPTH-2:0], in_idx};
    end
  end

  assign out_vld = vld_pipe[DEPTH-1];
  assign out_idx = idx_pipe[DEPTH-1];
  assign any_vld = |vld_pipe;
endmodule

// File: rtl/smult_sequencer.sv
// Streams a source vector through an external pipelined fp16 multiplier, writing
// scalar*element products to a destination vector and tracking sticky overflow.
module smult_sequencer #(
  parameter int VLEN    = smult_pkg::VLEN,
  parameter int IDX_W   = smult_pkg::IDX_W,
  parameter int REG_W   = smult_pkg::REG_W,
  parameter int MUL_LAT = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [REG_W-1:0] src_reg,
  input  logic [REG_W-1:0] dst_reg,
  input  logic [15:0]      scalar,
  input  logic [IDX_W:0]   len,
  output logic             busy,
  output logic             done,
  output logic             V,
  output logic             rd_en,
  output logic [REG_W-1:0] rd_reg,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [15:0]      rd_data,
  output logic [15:0]      mul_a,
  output logic [15:0]      mul_b,
  input  logic [15:0]      mul_p,
  input  logic             mul_ov,
  output logic             wr_en,
  output logic [REG_W-1:0] wr_reg,
  output logic [IDX_W-1:0] wr_idx,
  output logic [15:0]      wr_data
);
  import smult_pkg::*;

  localparam logic [IDX_W:0] VLEN_C = (IDX_W+1)'(VLEN);

  state_t             state, nstate;
  logic [IDX_W:0]     cnt, len_q, len_clamp;
  logic [15:0]        scal_q;
  logic [REG_W-1:0]   src_q, dst_q;
  logic               tail_vld, any_vld, accept;
  logic [IDX_W-1:0]   tail_idx;

  assign len_clamp = (len > VLEN_C) ? VLEN_C : len;
  assign accept    = (state == S_IDLE) && start;

  smult_tag_pipe #(.IDX_W(IDX_W), .DEPTH(1 + MUL_LAT)) u_tags (
    .Clk     (Clk),
    .Rst     (Rst),
    .in_vld  (rd_en),
    .in_idx  (cnt[IDX_W-1:0]),
    .out_vld (tail_vld),
    .out_idx (tail_idx),
    .any_vld (any_vld)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      len_q   <= '0;
      scal_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      V       <= 1'b0;
      wr_en   <= 1'b0;
      wr_idx  <= '0;
      wr_data <= '0;
    end else begin
      state <= nstate;
      if (accept) begin
        scal_q <= scalar;
        src_q  <= src_reg;
        dst_q  <= dst_reg;
        len_q  <= len_clamp;
        cnt    <= '0;
        V      <= 1'b0;
      end else if (state == S_ISSUE) begin
        cnt <= cnt + 1'b1;
      end
      // the tag tail lines up with the product from the same element
      wr_en <= tail_vld;
      if (tail_vld) begin
        wr_idx  <= tail_idx;
        wr_data <= mul_p;
        V       <= V | mul_ov;
      end
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:   if (start) nstate = (len_clamp == '0) ? S_FINISH : S_ISSUE;
      S_ISSUE:  if (cnt == len_q - 1'b1) nstate = S_DRAIN;
      S_DRAIN:  if (!any_vld) nstate = S_FINISH;
      S_FINISH: nstate = S_IDLE;
      default:  nstate = S_IDLE;
    endcase
  end

  assign busy   = (state != S_IDLE);
  assign done   = (state == S_FINISH);
  assign rd_en  = (state == S_ISSUE);
  assign rd_idx = cnt[IDX_W-1:0];
  assign rd_reg = src_q;
  assign wr_reg = dst_q;
  assign mul_a  = scal_q;
  assign mul_b  = rd_data;
endmodule

// File: tb/tb_smult_sequencer.sv
// Directed + randomized bench: two sequencers (MUL_LAT 1 and 3) with register-file and multiplier models.
module tb_smult_sequencer;
  import smult_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        start [2];
  logic [2:0]  src_reg, dst_reg;
  logic [15:0] scalar;
  logic [4:0]  len;

  logic        busy [2], done [2], V [2], rd_en [2], wr_en [2], mul_ov [2];
  logic [2:0]  rd_reg [2], wr_reg [2];
  logic [3:0]  rd_idx [2], wr_idx [2];
  logic [15:0] rd_data [2], mul_a [2], mul_b [2], mul_p [2], wr_data [2];

  logic [15:0] mem [2][8][16];
  logic [15:0] pa [2][3], pb [2][3];
  logic        ld_en;
  logic [2:0]  ld_reg;
  logic [15:0] ld_vec [16];

  int vecs = 0;
  int errs = 0;

  localparam logic [15:0] SCL [6] = '{16'h3c00, 16'hbc00, 16'h4000, 16'h7bff, 16'h3555, 16'h4a00};
  localparam logic [15:0] PW  [7] = '{16'h3800, 16'h3c00, 16'h4000, 16'h4400, 16'hc000, 16'hbc00, 16'h5800};

  always #5 Clk = ~Clk;

  smult_sequencer #(.MUL_LAT(1)) u0 (
    .Clk(Clk), .Rst(Rst), .start(start[0]), .src_reg(src_reg), .dst_reg(dst_reg),
    .scalar(scalar), .len(len), .busy(busy[0]), .done(done[0]), .V(V[0]),
    .rd_en(rd_en[0]), .rd_reg(rd_reg[0]), .rd_idx(rd_idx[0]), .rd_data(rd_data[0]),
    .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_p(mul_p[0]), .mul_ov(mul_ov[0]),
    .wr_en(wr_en[0]), .wr_reg(wr_reg[0]), .wr_idx(wr_idx[0]), .wr_data(wr_data[0]));

  smult_sequencer #(.MUL_LAT(3)) u1 (
    .Clk(Clk), .Rst(Rst), .start(start[1]), .src_reg(src_reg), .dst_reg(dst_reg),
    .scalar(scalar), .len(len), .busy(busy[1]), .done(done[1]), .V(V[1]),
    .rd_en(rd_en[1]), .rd_reg(rd_reg[1]), .rd_idx(rd_idx[1]), .rd_data(rd_data[1]),
    .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_p(mul_p[1]), .mul_ov(mul_ov[1]),
    .wr_en(wr_en[1]), .wr_reg(wr_reg[1]), .wr_idx(wr_idx[1]), .wr_data(wr_data[1]));

  // fp16 product where b is a power of two: exponents add, mantissa of a kept, saturate to inf
  function automatic logic [16:0] fmul(input logic [15:0] a, input logic [15:0] b);
    int e;
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (e >= 31) return {1'b1, a[15] ^ b[15], 5'h1f, 10'h000};
    return {1'b0, a[15] ^ b[15], e[4:0], a[9:0]};
  endfunction

  // register file and multiplier pipeline around each sequencer
  always @(posedge Clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en[k]) rd_data[k] <= mem[k][rd_reg[k]][rd_idx[k]];
      if (wr_en[k]) mem[k][wr_reg[k]][wr_idx[k]] <= wr_data[k];
      pa[k][0] <= mul_a[k];
      pb[k][0] <= mul_b[k];
      for (int s = 1; s < 3; s++) begin
        pa[k][s] <= pa[k][s-1];
        pb[k][s] <= pb[k][s-1];
      end
    end
    if (ld_en)
      for (int i = 0; i < 16; i++) begin
        mem[0][ld_reg][i] <= ld_vec[i];
        mem[1][ld_reg][i] <= ld_vec[i];
      end
  end

  assign {mul_ov[0], mul_p[0]} = fmul(pa[0][0], pb[0][0]);
  assign {mul_ov[1], mul_p[1]} = fmul(pa[1][2], pb[1][2]);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [2:0] r, input logic [15:0] fill, input int odd_idx,
                      input logic [15:0] odd_val, input bit rnd);
    ld_reg = r;
    for (int i = 0; i < 16; i++)
      ld_vec[i] = rnd ? PW[$urandom_range(6)] : ((i == odd_idx) ? odd_val : fill);
    ld_en = 1'b1;
    @(negedge Clk);
    ld_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input int k, input string tag);
    chk(tag, {busy[k], done[k], V[k], rd_en[k], wr_en[k], rd_reg[k], rd_idx[k],
              wr_reg[k], wr_idx[k], wr_data[k], mul_a[k]}, 64'd0);
  endtask

  // One operation on instance k; cycle c counts cycles after the accept edge.
  task automatic run_op(input int k, input logic [2:0] s, input logic [2:0] d,
                        input logic [15:0] sc, input logic [4:0] ln,
                        input bit mid, input int rst_w);
    int L, n, dc, wi;
    logic [15:0] sv [16];
    logic [15:0] dv [16];
    logic [16:0] r;
    logic expV;
    bit exp_rd, exp_wr;
    L = (k == 0) ? 1 : 3;
    n = (ln > 16) ? 16 : int'(ln);
    dc = (n == 0) ? 1 : 3 + L + n;
    expV = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sv[i] = mem[k][s][i];
      dv[i] = mem[k][d][i];
    end
    for (int i = 0; i < n; i++) begin
      r = fmul(sc, sv[i]);
      dv[i] = r[15:0];
      expV |= r[16];
    end
    start[k] = 1'b1; src_reg = s; dst_reg = d; scalar = sc; len = ln;
    @(negedge Clk);
    start[k] = 1'b0;
    for (int c = 1; c <= dc + 2; c++) begin
      if (c > 1) @(negedge Clk);
      exp_rd = (c <= n);
      wi = c - 3 - L;
      exp_wr = (wi >= 0) && (wi < n);
      chk("ctl", {busy[k], done[k], rd_en[k], wr_en[k]}, {c <= dc, c == dc, exp_rd, exp_wr});
      if (exp_rd) chk("rd", {rd_reg[k], rd_idx[k]}, {s, 4'(c - 1)});
      if (exp_wr) chk("wr", {wr_reg[k], wr_idx[k], wr_data[k]}, {d, 4'(wi), dv[wi]});
      if (c == 1) chk("v_clr", V[k], 1'b0);
      if (c >= dc) chk("v", V[k], expV);
      if (mid && c == 4) begin start[k] = 1'b1; scalar = 16'h4000; len = 5'd0; end
      if (mid && c == 5) start[k] = 1'b0;
      if (rst_w > 0 && exp_wr && wi == rst_w - 1) begin
        Rst = 1'b1;
        #1;
        check_reset_outputs(k, "rst_now");
        for (int j = 0; j < 3; j++) begin
          @(negedge Clk);
          chk("rst_hold", {busy[k], done[k], wr_en[k], rd_en[k]}, 4'd0);
        end
        Rst = 1'b0;
        @(negedge Clk);
        return;
      end
    end
    for (int i = 0; i < 16; i++) chk("mem", mem[k][d][i], dv[i]);
  endtask

  initial begin
    Rst = 1'b1; start[0] = 1'b0; start[1] = 1'b0; ld_en = 1'b0; ld_reg = '0;
    src_reg = '0; dst_reg = '0; scalar = '0; len = '0;
    for (int i = 0; i < 16; i++) ld_vec[i] = '0;
    repeat (2) @(negedge Clk);
    check_reset_outputs(0, "reset0");
    check_reset_outputs(1, "reset1");
    Rst = 1'b0;
    @(negedge Clk);

    load(3'd0, ONE, -1, ONE, 0);
    load(3'd1, ONE, 5, 16'h4000, 0);
    load(3'd2, ONE, -1, ONE, 0);
    for (int r = 3; r < 8; r++) load(3'(r), 16'h0000, -1, 16'h0000, 1);

    run_op(0, 3'd0, 3'd3, ONE, 5'd16, 0, 0);        // basic, done at +20
    run_op(0, 3'd0, 3'd4, NEG_ONE, 5'd16, 1, 0);    // sign flip, ignored second start
    run_op(0, 3'd1, 3'd5, MAX, 5'd16, 0, 0);        // overflow on element 5 only
    repeat (3) @(negedge Clk);
    chk("v_held", V[0], 1'b1);
    run_op(0, 3'd0, 3'd6, ONE, 5'd0, 0, 0);         // len 0, also clears V
    chk("v_after", V[0], 1'b0);
    run_op(0, 3'd0, 3'd6, NEG_ONE, 5'd20, 0, 0);    // clamp to 16
    run_op(0, 3'd2, 3'd2, 16'h4000, 5'd16, 0, 0);   // in place
    load(3'd2, ONE, -1, ONE, 0);
    run_op(1, 3'd2, 3'd2, 16'h4000, 5'd16, 0, 0);   // in place, MUL_LAT 3
    run_op(0, 3'd0, 3'd7, ONE, 5'd16, 0, 8);        // reset at 8th write
    run_op(0, 3'd0, 3'd7, 16'h4000, 5'd16, 0, 0);

    for (int r = 0; r < 5; r++) load(3'(r), 16'h0000, -1, 16'h0000, 1);
    for (int t = 0; t < 12; t++)
      run_op(int'($urandom_range(1)), 3'($urandom_range(4)), 3'($urandom_range(7, 5)),
             SCL[$urandom_range(5)], 5'($urandom_range(20)), bit'($urandom_range(1)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
